crc_sort_io_ctrl: RTL and testbench
===================================

# crc_sort_io_ctrl

Byte-stream front end for the CRC/sort compute core. It collects 16 input bytes into a 128-bit frame, latches the function code, and issues the frame to the core with a one-cycle start. It then waits for core done, captures the core result and streams it out as bytes over a valid/ready interface. It sits directly upstream of the core's `start`/`data_in`/`fn_sel`/`en` inputs and downstream of its `data_out`/`done` outputs.

## Interface
- `BYTES`, 16, bytes per frame; fixed by the core width, not to be overridden.
- `CORE_TIMEOUT`, 255, maximum cycles spent in WAIT before a fault.

Ports. Reset is `rst`, asynchronous, active-high; the clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `in_valid`  in  1  input byte valid
- `in_data`  in  8  input byte
- `in_fn`  in  3  function code, sampled with the first byte of a frame
- `in_ready`  out  1  block accepts a byte
- `out_valid`  out  1  output byte valid
- `out_data`  out  8  output byte
- `out_last`  out  1  final byte of the result
- `out_ready`  in  1  downstream accepts a byte
- `core_en`  out  1  core enable
- `core_start`  out  1  core start pulse
- `core_fn_sel`  out  3  core function select
- `core_data_in`  out  128  frame to the core
- `core_data_out`  in  128  core result
- `core_done`  in  1  core done
- `busy`  out  1  high in every state except COLLECT
- `drop`  out  1  one-cycle pulse: frame discarded because of an unsupported fn
- `fault`  out  1  sticky core timeout

## Operation
- Supported function codes: FN_CRC_GEN=3'b011 and FN_SORT=3'b100.
- **COLLECT**
  - `in_ready`=1; a byte transfers when `in_valid`&&`in_ready`.
  - Byte k (0-based) is written to `core_data_in[127-8k -: 8]`, so the first byte lands in the MSB position.
  - `in_fn` is latched into `core_fn_sel` on the transfer of byte 0.
  - On the transfer of byte 15: go to ISSUE if the fn is supported. Otherwise pulse `drop`, stay in COLLECT and reset the byte count.
- **ISSUE** (1 cycle): `core_start`=1, `core_en`=1, then go to WAIT.
- **WAIT**
  - `core_en`=1; the timeout counter increments every cycle.
  - If `core_done`=1: load the result register from `core_data_out` and go to DRAIN.
    - CRC_GEN: result is the single byte {5'b0, `core_data_out[2:0]`}.
    - SORT: result is 16 bytes, drained from `[127:120]` down to `[7:0]`.
  - If the counter reaches CORE_TIMEOUT with no done: go to FAULT.
- **DRAIN**
  - `core_en`=1, so the core leaves its DONE state.
  - `out_valid`=1 and `out_data` = current result byte.
  - Advance on `out_valid`&&`out_ready`.
  - `out_last`=1 on the final byte (the only byte for CRC, byte 15 for SORT).
  - After the last transfer, go to COLLECT with the byte count reset to 0.
- **FAULT**
  - `fault`=1, `core_en`=0, `in_ready`=0, `out_valid`=0.
  - Only `rst` exits FAULT.
- **Reset**
  - State → COLLECT.
  - Counters → 0.
  - `in_ready`=1 once `rst` deasserts.
  - All other outputs are 0, including `core_data_in`, `core_fn_sel`, `out_data`.
- Reset in the middle of a frame or drain discards everything; no partial output follows.
- `core_data_in` and `core_fn_sel` are held stable from ISSUE until byte 0 of the next frame.

## Timing
- All outputs are decoded from registers; there is no combinational path from `out_ready`/`in_valid` to `in_ready`/`out_valid`.
- Byte 15 accepted at cycle T → ISSUE at T+1 → WAIT from T+2.
- SORT: `core_done` at T+19, first `out_valid` at T+20.
- CRC: `core_done` at T+131, `out_valid` at T+132.
- `out_data`/`out_valid`/`out_last` stay stable while `out_ready`=0.
- No input byte is accepted between byte 15 and the end of DRAIN.
- A `core_done` seen outside WAIT is ignored.
- If timeout and done occur in the same cycle, done wins.

## Structure
- Package `crc_sort_pkg`: FN_CRC_GEN, FN_SORT, BYTES, and the state encoding (COLLECT, ISSUE, WAIT, DRAIN, FAULT).
- One sub-module, `crc_sort_frame_pack`: a 16-byte deserializer with byte counter, holding the frame register and the byte-15 strobe.
- FSM, timeout counter and result shift register live in the top module.

## Test plan
- **SORT frame:** bytes 0x00..0x0F in order with fn=100 → output 0x0F,0x0E,...,0x00; `out_last` only with 0x00; first `out_valid` 19 cycles after ISSUE.
- **CRC frame:** fifteen 0x00 then 0x01, fn=011 → exactly one output byte 0x05 with `out_last`=1; all-zero frame → 0x00.
- **Backpressure:** SORT drain with `out_ready` toggled 1/0 each cycle → 16 bytes in order, no duplicates or losses; data held while `out_ready`=0.
- **Bad fn:** 16 bytes with fn=3'b001 → `drop` pulses one cycle after byte 15; no `core_start`; the next valid SORT frame completes normally.
- **Timeout:** core model never asserts done → `fault`=1 at CORE_TIMEOUT cycles into WAIT; `in_ready` stays 0; `rst` clears it.
- **Reset mid-op:** assert `rst` during WAIT and during DRAIN byte 5 → all outputs are 0 during reset, no output bytes afterwards, and a fresh frame processes correctly.

Source files
------------

// File: rtl/crc_sort_pkg.sv
// Shared constants and state encoding for the CRC/sort core byte-stream front end.
package crc_sort_pkg;

    localparam int BYTES = 16;

    localparam logic [2:0] FN_CRC_GEN = 3'b011;
    localparam logic [2:0] FN_SORT    = 3'b100;

    typedef enum logic [2:0] {
        COLLECT,
        ISSUE,
        WAIT,
        DRAIN,
        FAULT
    } state_e;

    function automatic logic fn_supported(input logic [2:0] fn);
        return (fn == FN_CRC_GEN) || (fn == FN_SORT);
    endfunction

endpackage

// File: rtl/crc_sort_frame_pack.sv
// 16-byte deserializer: first byte lands in the MSB slot, fn is captured with byte 0.
module crc_sort_frame_pack
    import crc_sort_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_i,
    input  logic [7:0]         data_i,
    input  logic [2:0]         fn_i,
    output logic [8*BYTES-1:0] frame_o,
    output logic [2:0]         fn_o,
    output logic               last_o
);
    localparam int CW = $clog2(BYTES);

    logic [CW-1:0]      cnt_q;
    logic [8*BYTES-1:0] frame_q;
    logic [2:0]         fn_q;

    // The counter wraps to 0 after the last byte, so every frame (issued or
    // dropped) restarts at slot 0 without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            frame_q <= '0;
            fn_q    <= '0;
        end else if (wr_i) begin
            frame_q[(BYTES-1-int'(cnt_q))*8 +: 8] <= data_i;
            if (cnt_q == '0)
                fn_q <= fn_i;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign frame_o = frame_q;
    assign fn_o    = fn_q;
    assign last_o  = wr_i && (cnt_q == CW'(BYTES-1));

endmodule

// File: rtl/crc_sort_io_ctrl.sv
// Front end: collects a frame, starts the core, waits for done, streams the result out.
module crc_sort_io_ctrl
    import crc_sort_pkg::*;
#(
    parameter int CORE_TIMEOUT = 255
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic [2:0]         in_fn,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               core_en,
    output logic               core_start,
    output logic [2:0]         core_fn_sel,
    output logic [8*BYTES-1:0] core_data_in,
    input  logic [8*BYTES-1:0] core_data_out,
    input  logic               core_done,
    output logic               busy,
    output logic               drop,
    output logic               fault
);
    localparam int TW = $clog2(CORE_TIMEOUT + 1);
    localparam int LW = $clog2(BYTES);

    state_e             state_q;
    logic [TW-1:0]      tmo_q;
    logic [8*BYTES-1:0] res_q;
    logic [LW-1:0]      left_q;
    logic               in_ready_q, out_valid_q, out_last_q, core_en_q, core_start_q;
    logic               busy_q, drop_q, fault_q;
    logic [7:0]         out_data_q;
    logic               frame_done;
    logic [2:0]         fn;

    crc_sort_frame_pack u_pack (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (in_valid && in_ready_q),
        .data_i  (in_data),
        .fn_i    (in_fn),
        .frame_o (core_data_in),
        .fn_o    (fn),
        .last_o  (frame_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            tmo_q        <= '0;
            res_q        <= '0;
            left_q       <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            core_en_q    <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            drop_q       <= 1'b0;
            case (state_q)
                COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (frame_done) begin
                        if (fn_supported(fn)) begin
                            state_q      <= ISSUE;
                            in_ready_q   <= 1'b0;
                            core_start_q <= 1'b1;
                            core_en_q    <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    tmo_q   <= '0;
                end
                WAIT: begin
                    // done is tested first so it wins over a same-cycle timeout
                    if (core_done) begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        if (fn == FN_CRC_GEN) begin
                            out_data_q <= {5'b0, core_data_out[2:0]};
                            left_q     <= '0;
                            out_last_q <= 1'b1;
                        end else begin
                            out_data_q <= core_data_out[8*BYTES-1 -: 8];
                            res_q      <= {core_data_out[8*BYTES-9:0], 8'h00};
                            left_q     <= LW'(BYTES-1);
                            out_last_q <= 1'b0;
                        end
                    end else if (tmo_q == TW'(CORE_TIMEOUT-1)) begin
                        state_q   <= FAULT;
                        fault_q   <= 1'b1;
                        core_en_q <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (left_q == '0) begin
                            state_q     <= COLLECT;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            core_en_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            out_data_q <= res_q[8*BYTES-1 -: 8];
                            res_q      <= {res_q[8*BYTES-9:0], 8'h00};
                            left_q     <= left_q - 1'b1;
                            out_last_q <= (left_q == LW'(1));
                        end
                    end
                end
                FAULT: ;
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign core_en     = core_en_q;
    assign core_start  = core_start_q;
    assign core_fn_sel = fn;
    assign busy        = busy_q;
    assign drop        = drop_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_crc_sort_io_ctrl.sv
// Directed bench: stub core (descending sort / CRC-3 x^3+x^2+1) plus an output scoreboard.
module tb_crc_sort_io_ctrl;
    import crc_sort_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_last, out_ready;
    logic [7:0]   in_data, out_data;
    logic [2:0]   in_fn, core_fn_sel;
    logic         core_en, core_start, core_done, busy, drop, fault;
    logic [127:0] core_data_in, core_data_out;

    crc_sort_io_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_fn(in_fn), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .core_en(core_en), .core_start(core_start), .core_fn_sel(core_fn_sel),
        .core_data_in(core_data_in), .core_data_out(core_data_out), .core_done(core_done),
        .busy(busy), .drop(drop), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic l; } exp_t;
    exp_t       expq[$];
    logic [7:0] got[$];
    int ntests = 0, nfail = 0, cyc = 0, tacc = 0, cd = 0;
    logic core_hang = 1'b0, inject_done = 1'b0, bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] crc3(input logic [127:0] m);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = 127; i >= 0; i--) begin
            fb = r[2] ^ m[i];
            r  = {r[1:0], 1'b0} ^ (fb ? 3'b101 : 3'b000);
        end
        return r;
    endfunction

    function automatic logic [127:0] sort_desc(input logic [127:0] f);
        int q[$];
        logic [127:0] r;
        for (int k = 0; k < 16; k++) q.push_back(int'(f[127-8*k -: 8]));
        q.rsort();
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = 8'(q[k]);
        return r;
    endfunction

    // Stub core: done 17 edges after the start edge for SORT, 129 for CRC.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_done     <= 1'b0;
            core_data_out <= '0;
            cd            <= 0;
        end else begin
            core_done <= inject_done;
            if (core_start && !core_hang) begin
                cd <= (core_fn_sel == FN_SORT) ? 17 : 129;
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    core_done <= 1'b1;
                    core_data_out <= (core_fn_sel == FN_SORT) ? sort_desc(core_data_in)
                                   : {~core_data_in[127:3], crc3(core_data_in)};
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        out_ready = bp ? ~out_ready : 1'b1;
    end

    // Scoreboard: checked after all negedge-time drivers have settled.
    logic pv = 1'b0, pr = 1'b0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) chk1("hold_valid", out_valid, 1'b1);
            if (busy) chk1("ready_while_busy", in_ready, 1'b0);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_out: got byte %0h, expected no output", out_data);
                end else begin
                    chkv("out_data", 128'(out_data), 128'(expq[0].d));
                    chk1("out_last", out_last, expq[0].l);
                    if (out_ready) begin
                        got.push_back(out_data);
                        void'(expq.pop_front());
                    end
                end
            end
            pv = out_valid;
            pr = out_ready;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [127:0] f, input logic [2:0] fn);
        int   q[$];
        exp_t e;
        if (fn == FN_SORT) begin
            for (int k = 0; k < 16; k++) q.push_back(int'(f[127-8*k -: 8]));
            q.rsort();
            for (int k = 0; k < 16; k++) begin
                e.d = 8'(q[k]);
                e.l = (k == 15);
                expq.push_back(e);
            end
        end else begin
            e.d = {5'b0, crc3(f)};
            e.l = 1'b1;
            expq.push_back(e);
        end
    endtask

    // Later bytes carry the complement fn to show only byte 0's fn is used.
    task automatic send_frame(input logic [127:0] f, input logic [2:0] fn);
        int w;
        for (int k = 0; k < 16; k++) begin
            w = 0;
            while (!in_ready && w < 500) begin step(); w++; end
            if (!in_ready) chk1("in_ready_timeout", in_ready, 1'b1);
            in_valid = 1'b1;
            in_data  = f[127-8*k -: 8];
            in_fn    = (k == 0) ? fn : ~fn;
            step();
        end
        in_valid = 1'b0;
        tacc = cyc;
        if (fn_supported(fn) && !core_hang) push_exp(f, fn);
    endtask

    task automatic wait_idle(input string nm);
        int w;
        w = 0;
        while ((expq.size() != 0 || busy || out_valid) && w < 3000) begin step(); w++; end
        chk1(nm, (expq.size() == 0) && !busy && !out_valid, 1'b1);
    endtask

    task automatic wait_valid(input string nm, input int lat);
        int w;
        w = 0;
        while (!out_valid && w < 400) begin step(); w++; end
        chkv(nm, 128'(cyc - tacc), 128'(lat));
    endtask

    task automatic check_reset(input string nm);
        chk1({nm, "_in_ready"}, in_ready, 1'b0);
        chk1({nm, "_out_valid"}, out_valid, 1'b0);
        chk1({nm, "_out_last"}, out_last, 1'b0);
        chkv({nm, "_out_data"}, 128'(out_data), 128'(0));
        chk1({nm, "_core_en"}, core_en, 1'b0);
        chk1({nm, "_core_start"}, core_start, 1'b0);
        chkv({nm, "_core_fn_sel"}, 128'(core_fn_sel), 128'(0));
        chkv({nm, "_core_data_in"}, core_data_in, 128'(0));
        chk1({nm, "_busy"}, busy, 1'b0);
        chk1({nm, "_drop"}, drop, 1'b0);
        chk1({nm, "_fault"}, fault, 1'b0);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        expq.delete();
        step();
        check_reset(nm);
        step();
        rst = 1'b0;
        step();
        step();
        chk1({nm, "_ready_after"}, in_ready, 1'b1);
    endtask

    logic [127:0] pat;
    int           w;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_fn = '0; out_ready = 1'b1;
        repeat (3) step();
        check_reset("por");
        rst = 1'b0;
        step();
        step();
        chk1("ready_after_reset", in_ready, 1'b1);
        chk1("idle_busy", busy, 1'b0);

        // SORT of 0x00..0x0F
        got.delete();
        send_frame(128'h000102030405060708090A0B0C0D0E0F, FN_SORT);
        chk1("sort_start", core_start, 1'b1);
        chkv("sort_frame", core_data_in, 128'h000102030405060708090A0B0C0D0E0F);
        chkv("sort_fn", 128'(core_fn_sel), 128'(FN_SORT));
        chk1("sort_in_ready_low", in_ready, 1'b0);
        step();
        chk1("start_one_cycle", core_start, 1'b0);
        chk1("core_en_wait", core_en, 1'b1);
        wait_valid("sort_latency", 19);
        wait_idle("sort_idle");
        chkv("sort_count", 128'(got.size()), 128'(16));
        chkv("sort_first", 128'(got[0]), 128'h0F);
        chkv("sort_last", 128'(got[15]), 128'h00);
        chkv("sort_frame_held", core_data_in, 128'h000102030405060708090A0B0C0D0E0F);

        // CRC: fifteen zeros then 0x01, then an all-zero frame
        got.delete();
        send_frame(128'h1, FN_CRC_GEN);
        wait_valid("crc_latency", 131);
        wait_idle("crc_idle");
        chkv("crc_count", 128'(got.size()), 128'(1));
        chkv("crc_value", 128'(got[0]), 128'h05);
        got.delete();
        send_frame(128'h0, FN_CRC_GEN);
        wait_idle("crc0_idle");
        chkv("crc0_value", 128'(got[0]), 128'h00);

        // Backpressure with out_ready toggling every cycle, unsorted pattern
        for (int k = 0; k < 16; k++) pat[127-8*k -: 8] = 8'((k * 37 + 11) % 256);
        got.delete();
        bp = 1'b1;
        send_frame(pat, FN_SORT);
        wait_idle("bp_idle");
        bp = 1'b0;
        chkv("bp_count", 128'(got.size()), 128'(16));

        // Unsupported fn: dropped, no start, next frame fine
        send_frame(pat, 3'b001);
        chk1("drop_pulse", drop, 1'b1);
        chk1("drop_no_start", core_start, 1'b0);
        chk1("drop_not_busy", busy, 1'b0);
        chk1("drop_ready", in_ready, 1'b1);
        step();
        chk1("drop_one_cycle", drop, 1'b0);
        repeat (3) begin step(); chk1("drop_no_start_later", core_start, 1'b0); end
        got.delete();
        send_frame(pat, FN_SORT);
        wait_idle("after_drop_idle");
        chkv("after_drop_count", 128'(got.size()), 128'(16));

        // core_done while collecting must be ignored
        inject_done = 1'b1;
        step();
        inject_done = 1'b0;
        repeat (3) step();
        chk1("spurious_done_busy", busy, 1'b0);
        chk1("spurious_done_valid", out_valid, 1'b0);

        // Core never answers: fault at CORE_TIMEOUT cycles into WAIT
        core_hang = 1'b1;
        send_frame(pat, FN_SORT);
        repeat (255) step();
        chk1("fault_not_early", fault, 1'b0);
        step();
        chk1("fault_set", fault, 1'b1);
        chk1("fault_in_ready", in_ready, 1'b0);
        chk1("fault_core_en", core_en, 1'b0);
        chk1("fault_out_valid", out_valid, 1'b0);
        repeat (20) step();
        chk1("fault_sticky", fault, 1'b1);
        chk1("fault_ready_stays", in_ready, 1'b0);
        core_hang = 1'b0;
        do_reset("rst_fault");

        // Reset during WAIT, then a fresh CRC frame
        got.delete();
        send_frame(pat, FN_SORT);
        repeat (5) step();
        do_reset("rst_wait");
        repeat (40) step();
        chkv("rst_wait_no_out", 128'(got.size()), 128'(0));
        send_frame(128'h1, FN_CRC_GEN);
        wait_idle("rst_wait_fresh");
        chkv("rst_wait_fresh_val", 128'(got[0]), 128'h05);

        // Reset during DRAIN byte 5, then a fresh SORT frame
        got.delete();
        send_frame(128'h000102030405060708090A0B0C0D0E0F, FN_SORT);
        w = 0;
        while (got.size() < 5 && w < 400) begin step(); w++; end
        chkv("drain_reached_5", 128'(got.size()), 128'(5));
        do_reset("rst_drain");
        repeat (30) step();
        chkv("rst_drain_no_more", 128'(got.size()), 128'(5));
        got.delete();
        send_frame(pat, FN_SORT);
        wait_idle("rst_drain_fresh");
        chkv("rst_drain_fresh_count", 128'(got.size()), 128'(16));

        chkv("queue_empty", 128'(expq.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
